// File: rtl/sort_sequencer.sv
// sort_sequencer: debounced colour decision, timed servo gate and saturating accept/reject tallies
module sort_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int SETTLE_CYCLES   = 20_000_000,
    parameter int COUNT_MAX       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        red_detected,
    input  logic        green_detected,
    input  logic        blue_detected,
    input  logic [2:0]  SW,
    output logic        gate_on,
    output logic        led_accept,
    output logic        led_reject,
    output logic        busy,
    output logic [13:0] accept_count,
    output logic [13:0] reject_count
);
    typedef enum logic [1:0] {IDLE, QUALIFY, ACTUATE, SETTLE} state_t;

    localparam logic [13:0] CMAX = 14'(COUNT_MAX);

    state_t      state;
    logic [2:0]  v;
    logic [2:0]  ref_v;
    logic [31:0] cnt;
    logic        rej_flag;
    logic        one_hot;
    logic        accept;

    assign v       = {blue_detected, green_detected, red_detected};
    assign one_hot = (ref_v != 3'd0) && ((ref_v & (ref_v - 3'd1)) == 3'd0);
    assign accept  = one_hot && ((ref_v & SW) != 3'd0);

    // Sequencer: cnt is reused as debounce run length, hold timer and settle run length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ref_v        <= 3'd0;
            cnt          <= 32'd0;
            rej_flag     <= 1'b0;
            gate_on      <= 1'b0;
            led_accept   <= 1'b0;
            led_reject   <= 1'b0;
            busy         <= 1'b0;
            accept_count <= 14'd0;
            reject_count <= 14'd0;
        end else begin
            case (state)
                IDLE: if (v != 3'd0) begin
                    state <= QUALIFY;
                    ref_v <= v;
                    cnt   <= 32'd1;
                    busy  <= 1'b1;
                end
                QUALIFY: if (v == 3'd0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (v != ref_v) begin
                    ref_v <= v;
                    cnt   <= 32'd1;
                end else if (cnt < 32'(DEBOUNCE_CYCLES)) begin
                    cnt <= cnt + 32'd1;
                end else if (accept) begin
                    state        <= ACTUATE;
                    cnt          <= 32'd1;
                    gate_on      <= 1'b1;
                    led_accept   <= 1'b1;
                    accept_count <= (accept_count < CMAX) ? accept_count + 14'd1 : accept_count;
                end else begin
                    state        <= SETTLE;
                    cnt          <= 32'd0;
                    rej_flag     <= 1'b1;
                    led_reject   <= 1'b1;
                    reject_count <= (reject_count < CMAX) ? reject_count + 14'd1 : reject_count;
                end
                ACTUATE: if (cnt == 32'(HOLD_CYCLES)) begin
                    state      <= SETTLE;
                    cnt        <= 32'd0;
                    rej_flag   <= 1'b0;
                    gate_on    <= 1'b0;
                    led_accept <= 1'b0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                SETTLE: if (v != 3'd0) begin
                    cnt <= 32'd0;
                end else if (cnt + 32'd1 == 32'(SETTLE_CYCLES)) begin
                    state      <= IDLE;
                    cnt        <= 32'd0;
                    busy       <= 1'b0;
                    led_reject <= 1'b0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: directed and random stimulus checked cycle by cycle against a behavioural model
module tb_sort_sequencer;
    localparam int D = 4;
    localparam int H = 8;
    localparam int S = 3;
    localparam int CM = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        red_detected = 1'b0;
    logic        green_detected = 1'b0;
    logic        blue_detected = 1'b0;
    logic [2:0]  SW = 3'd0;
    logic        gate_on, led_accept, led_reject, busy;
    logic [13:0] accept_count, reject_count;

    int n_vec = 0;
    int n_err = 0;

    // 0 idle, 1 qualifying, 2 gate open, 3 settling
    int       m_phase = 0;
    int       m_run = 0;
    bit [2:0] m_ref = 3'd0;
    int       m_acc = 0;
    int       m_rej = 0;
    bit       m_rejflag = 1'b0;

    sort_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .SETTLE_CYCLES(S),
        .COUNT_MAX(CM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .red_detected(red_detected),
        .green_detected(green_detected),
        .blue_detected(blue_detected),
        .SW(SW),
        .gate_on(gate_on),
        .led_accept(led_accept),
        .led_reject(led_reject),
        .busy(busy),
        .accept_count(accept_count),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0;
        m_run = 0;
        m_ref = 3'd0;
        m_acc = 0;
        m_rej = 0;
        m_rejflag = 1'b0;
    endtask

    task automatic model_step(input bit [2:0] v, input bit [2:0] sw);
        if (m_phase == 0) begin
            if (v != 0) begin m_phase = 1; m_ref = v; m_run = 1; end
        end else if (m_phase == 1) begin
            if (v == 0) m_phase = 0;
            else if (v != m_ref) begin m_ref = v; m_run = 1; end
            else if (m_run < D) m_run++;
            else if ($countones(m_ref) == 1 && (m_ref & sw) != 0) begin
                m_phase = 2; m_run = 1; m_acc = (m_acc < CM) ? m_acc + 1 : m_acc;
            end else begin
                m_phase = 3; m_run = 0; m_rejflag = 1'b1; m_rej = (m_rej < CM) ? m_rej + 1 : m_rej;
            end
        end else if (m_phase == 2) begin
            if (m_run == H) begin m_phase = 3; m_run = 0; m_rejflag = 1'b0; end
            else m_run++;
        end else begin
            if (v != 0) m_run = 0;
            else begin m_run++; if (m_run == S) m_phase = 0; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("gate_on", 32'(gate_on), 32'(m_phase == 2));
        check("led_accept", 32'(led_accept), 32'(m_phase == 2));
        check("led_reject", 32'(led_reject), 32'(m_phase == 3 && m_rejflag));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("accept_count", 32'(accept_count), 32'(m_acc));
        check("reject_count", 32'(reject_count), 32'(m_rej));
    endtask

    task automatic tick(input bit [2:0] v, input bit [2:0] sw);
        {blue_detected, green_detected, red_detected} = v;
        SW = sw;
        @(posedge clk);
        model_step(v, sw);
        #1;
        check_all();
    endtask

    task automatic run(input bit [2:0] v, input bit [2:0] sw, input int n);
        for (int i = 0; i < n; i++) tick(v, sw);
    endtask

    initial begin
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        run(3'b000, 3'b001, 3);

        // accept: red held 20 cycles
        run(3'b001, 3'b001, 20);
        run(3'b000, 3'b001, 6);
        check("accept_item_acc", 32'(accept_count), 32'd1);
        check("accept_item_rej", 32'(reject_count), 32'd0);

        // reject: blue against green selection
        run(3'b100, 3'b010, 10);
        run(3'b000, 3'b010, 6);
        check("reject_item_rej", 32'(reject_count), 32'd1);

        // glitch shorter than debounce
        run(3'b001, 3'b001, 3);
        run(3'b000, 3'b001, 3);
        check("glitch_acc", 32'(accept_count), 32'd1);

        // colour change restarts qualification
        run(3'b001, 3'b010, 2);
        run(3'b010, 3'b010, 4);
        check("colour_change_pre", 32'(gate_on), 32'd0);
        tick(3'b010, 3'b010);
        check("colour_change_gate", 32'(gate_on), 32'd1);
        run(3'b010, 3'b010, 10);
        run(3'b000, 3'b010, 6);

        // ambiguous multi-hot reading
        run(3'b011, 3'b011, 10);
        run(3'b000, 3'b011, 6);
        check("ambiguous_rej", 32'(reject_count), 32'd2);

        // SW changes after decision do not matter; SW=0 rejects
        run(3'b100, 3'b000, 8);
        run(3'b000, 3'b000, 5);

        // reset in the third cycle of the hold
        run(3'b001, 3'b001, 7);
        check("pre_reset_gate", 32'(gate_on), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        run(3'b000, 3'b001, 4);

        // saturation of accept tally
        for (int k = 0; k < CM + 2; k++) begin
            run(3'b010, 3'b110, D + 1 + H);
            run(3'b000, 3'b110, S + 1);
        end
        check("sat_acc", 32'(accept_count), 32'(CM));

        // randomized segments
        for (int k = 0; k < 250; k++) begin
            bit [2:0] v;
            int len;
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) v = 3'd0;
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) tick(v, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
